// File: rtl/multicycle_controller_if.sv
// Control bundle between multicycle_controller and the 16-bit windowed datapath.
// master = controller: takes start/Instr, drives every control line and status flag.
// slave  = datapath/bench: drives start/Instr, observes controls and status.
interface multicycle_controller_if;
    logic        start;
    logic [15:0] Instr;
    logic        pcWrite;
    logic        ALUop2;
    logic        winEn;
    logic        memRead;
    logic        memWrite;
    logic        writeDataSel;
    logic        regWrite;
    logic        branch;
    logic        jump;
    logic [2:0]  ALUControl;
    logic        busy;
    logic        halted;
    logic        illegal;

    modport master (
        input  start, Instr,
        output pcWrite, ALUop2, winEn, memRead, memWrite,
        output writeDataSel, regWrite, branch, jump, ALUControl,
        output busy, halted, illegal
    );

    modport slave (
        output start, Instr,
        input  pcWrite, ALUop2, winEn, memRead, memWrite,
        input  writeDataSel, regWrite, branch, jump, ALUControl,
        input  busy, halted, illegal
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM: latches Instr into IR in FETCH, then sequences the
// datapath controls over 2 cycles (3 for LOAD). PC advance is gated by pcWrite.
// Ports: clk, rst (async, active-high), bus (master modport: start, Instr in;
// pcWrite, ALUop2, winEn, memRead, memWrite, writeDataSel, regWrite, branch,
// jump, ALUControl, busy, halted, illegal out), retired (PERF_CNT_EN only).
// Optional feature: define PERF_CNT_EN for the retired-instruction counter.
module multicycle_controller #(
    parameter int         RETIRE_W    = 16,
    parameter logic [3:0] HALT_OPCODE = 4'b0000
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_controller_if.master bus
`ifdef PERF_CNT_EN
    ,
    output logic [RETIRE_W-1:0]   retired
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_LOAD  = 4'b0001;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_JUMP  = 4'b0100;
    localparam logic [3:0] OP_BEQ   = 4'b0101;
    localparam logic [3:0] OP_RTYPE = 4'b1000;
    localparam logic [3:0] OP_WIN   = 4'b1001;
    localparam logic [3:0] OP_ADDI  = 4'b1100;
    localparam logic [3:0] OP_SUBI  = 4'b1101;
    localparam logic [3:0] OP_ANDI  = 4'b1110;
    localparam logic [3:0] OP_ORI   = 4'b1111;

    state_t      state, state_nx;
    logic [15:0] ir;
    logic [3:0]  op;
    logic [2:0]  fn;
    logic        ir_unused;

    logic        pc_write;
    logic        alu_op2;
    logic        win_en;
    logic        mem_read;
    logic        mem_write;
    logic        wd_sel;
    logic        reg_write;
    logic        br;
    logic        jmp;
    logic [2:0]  alu_ctl;
    logic        exec_bad;
    logic        ill_q;

    assign op = ir[15:12];
    assign fn = ir[4:2];
    // Register and window fields are consumed by the datapath, not here.
    assign ir_unused = ^{ir[11:5], ir[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir <= '0;
        end else if (state == S_FETCH) begin
            ir <= bus.Instr;
        end
    end

    // Sticky error flag; only a fresh start from IDLE/HALT clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ill_q <= 1'b0;
        end else if ((state == S_IDLE || state == S_HALT) && bus.start) begin
            ill_q <= 1'b0;
        end else if (exec_bad) begin
            ill_q <= 1'b1;
        end
    end

    // Halt is detected on the live word so the PC is never advanced past it.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE, S_HALT: begin
                if (bus.start) state_nx = S_FETCH;
            end
            S_FETCH: begin
                if (bus.Instr[15:12] == HALT_OPCODE) state_nx = S_HALT;
                else                                  state_nx = S_EXEC;
            end
            S_EXEC: begin
                if (op == OP_LOAD) state_nx = S_WB;
                else               state_nx = S_FETCH;
            end
            S_WB:    state_nx = S_FETCH;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        pc_write  = 1'b0;
        alu_op2   = 1'b0;
        win_en    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        wd_sel    = 1'b0;
        reg_write = 1'b0;
        br        = 1'b0;
        jmp       = 1'b0;
        alu_ctl   = 3'b000;
        exec_bad  = 1'b0;
        if (state == S_EXEC) begin
            pc_write = 1'b1;
            unique case (op)
                OP_LOAD: begin
                    mem_read = 1'b1;
                    pc_write = 1'b0;
                end
                OP_STORE: mem_write = 1'b1;
                OP_JUMP:  jmp       = 1'b1;
                OP_BEQ: begin
                    br      = 1'b1;
                    alu_ctl = 3'b001;
                end
                OP_RTYPE: begin
                    if (fn > 3'b101) begin
                        exec_bad = 1'b1;
                    end else begin
                        alu_ctl   = fn;
                        reg_write = 1'b1;
                    end
                end
                OP_WIN: win_en = 1'b1;
                OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: begin
                    alu_op2   = 1'b1;
                    reg_write = 1'b1;
                    alu_ctl   = {1'b0, op[1:0]};
                end
                default: exec_bad = 1'b1;
            endcase
        end else if (state == S_WB) begin
            mem_read  = 1'b1;
            wd_sel    = 1'b1;
            reg_write = 1'b1;
            pc_write  = 1'b1;
        end
    end

    assign bus.pcWrite      = pc_write;
    assign bus.ALUop2       = alu_op2;
    assign bus.winEn        = win_en;
    assign bus.memRead      = mem_read;
    assign bus.memWrite     = mem_write;
    assign bus.writeDataSel = wd_sel;
    assign bus.regWrite     = reg_write;
    assign bus.branch       = br;
    assign bus.jump         = jmp;
    assign bus.ALUControl   = alu_ctl;
    assign bus.busy         = (state == S_FETCH) || (state == S_EXEC)
                            || (state == S_WB);
    assign bus.halted       = (state == S_HALT);
    assign bus.illegal      = ill_q;

`ifdef PERF_CNT_EN
    // One tick per retiring cycle; wraps naturally from all-ones to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= '0;
        end else if (pc_write) begin
            retired <= retired + RETIRE_W'(1);
        end
    end
`endif

endmodule
